// File: rtl/ace_rle_loader.sv
// ace_rle_loader: streams an .ACE run-length encoded download from ioctl into RAM
module ace_rle_loader #(
  parameter int              AW          = 16,
  parameter logic [AW-1:0]   BASE_ADDR   = 'h2000,
  parameter logic [AW-1:0]   END_ADDR    = 'hFFFF,
  parameter logic [7:0]      ESC         = 8'hED,
  parameter int unsigned     HOLD_CYCLES = 3000000
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_download,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_wr,
  input  logic [7:0]    ioctl_dout,
  output logic          ioctl_wait,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_data,
  output logic          mem_wr,
  input  logic          mem_busy,
  output logic          loader_en,
  output logic          loader_reset,
  output logic          done,
  output logic          overflow
);
  localparam int HW = HOLD_CYCLES > 0 ? $clog2(HOLD_CYCLES + 1) : 1;
  typedef enum logic [2:0] {S_IDLE, S_HOLD, S_LIT, S_CNT, S_VAL, S_FILL, S_FIN} state_t;
  state_t state;
  logic [AW:0] addr;
  logic [AW:0] a_n;
  logic [7:0] cnt;
  logic [HW-1:0] hold;
  logic dl_q, start, stop, take, go, ovf;
  assign mem_addr = addr[AW-1:0];
  // edge detection, byte acceptance and next write address (extra MSB keeps the address from wrapping)
  always_comb begin
    start = ioctl_download & !dl_q & |ioctl_index;
    stop = !ioctl_download & dl_q;
    take = ioctl_wr & !ioctl_wait & |ioctl_index;
    go = !mem_wr | !mem_busy;
    a_n = mem_wr ? addr + 1'b1 : addr;
    ovf = addr > {1'b0, END_ADDR};
  end
  // loader FSM; dropped writes past END_ADDR still consume the run so the stream stays in sync
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= S_IDLE;
      addr <= {1'b0, BASE_ADDR};
      cnt <= '0;
      hold <= '0;
      dl_q <= ioctl_download;
      mem_data <= '0;
      mem_wr <= 1'b0;
      ioctl_wait <= 1'b0;
      loader_en <= 1'b0;
      loader_reset <= 1'b0;
      done <= 1'b0;
      overflow <= 1'b0;
    end else begin
      dl_q <= ioctl_download;
      loader_reset <= 1'b0;
      if (stop) begin
        loader_en <= 1'b0;
        ioctl_wait <= 1'b0;
        mem_wr <= 1'b0;
        state <= S_IDLE;
      end else if (start) begin
        loader_reset <= 1'b1;
        loader_en <= 1'b1;
        done <= 1'b0;
        overflow <= 1'b0;
        addr <= {1'b0, BASE_ADDR};
        ioctl_wait <= 1'b1;
        hold <= HW'(HOLD_CYCLES);
        mem_wr <= 1'b0;
        state <= S_HOLD;
      end else begin
        case (state)
          S_HOLD: begin
            if (hold <= HW'(1)) begin
              hold <= '0;
              ioctl_wait <= 1'b0;
              state <= S_LIT;
            end else hold <= hold - 1'b1;
          end
          S_LIT: if (take) begin
            if (ioctl_dout == ESC) state <= S_CNT;
            else begin
              mem_data <= ioctl_dout;
              cnt <= 8'd1;
              ioctl_wait <= 1'b1;
              mem_wr <= !ovf;
              overflow <= overflow | ovf;
              state <= S_FILL;
            end
          end
          S_CNT: if (take) begin
            if (ioctl_dout == 8'd0) begin
              done <= 1'b1;
              state <= S_FIN;
            end else begin
              cnt <= ioctl_dout;
              state <= S_VAL;
            end
          end
          S_VAL: if (take) begin
            mem_data <= ioctl_dout;
            ioctl_wait <= 1'b1;
            mem_wr <= !ovf;
            overflow <= overflow | ovf;
            state <= S_FILL;
          end
          S_FILL: if (go) begin
            addr <= a_n;
            if (cnt == 8'd1) begin
              mem_wr <= 1'b0;
              ioctl_wait <= 1'b0;
              state <= S_LIT;
            end else begin
              cnt <= cnt - 1'b1;
              mem_wr <= !(a_n > {1'b0, END_ADDR});
              overflow <= overflow | (a_n > {1'b0, END_ADDR});
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ace_rle_loader.sv
// tb_ace_rle_loader: directed bench with a write scoreboard for two loader instances
module tb_ace_rle_loader;
  logic clk_sys = 1'b0;
  logic reset = 1'b1;
  logic [1:0] dl = '0, wr = '0, busy = '0;
  logic [1:0] wt, mw, en, lr, dn, ov;
  logic [7:0] idx [2];
  logic [7:0] dout [2];
  logic [7:0] md [2];
  logic [15:0] ma [2];
  logic [24:0] q [$];
  int vectors = 0;
  int errs = 0;
  int nw [2];
  always #5 clk_sys = ~clk_sys;

  ace_rle_loader #(.AW(16), .BASE_ADDR(16'h2000), .END_ADDR(16'hFFFF), .ESC(8'hED), .HOLD_CYCLES(4)) dut0 (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(dl[0]), .ioctl_index(idx[0]),
    .ioctl_wr(wr[0]), .ioctl_dout(dout[0]), .ioctl_wait(wt[0]), .mem_addr(ma[0]),
    .mem_data(md[0]), .mem_wr(mw[0]), .mem_busy(busy[0]), .loader_en(en[0]),
    .loader_reset(lr[0]), .done(dn[0]), .overflow(ov[0]));

  ace_rle_loader #(.AW(16), .BASE_ADDR(16'h2000), .END_ADDR(16'h2001), .ESC(8'hED), .HOLD_CYCLES(4)) dut1 (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(dl[1]), .ioctl_index(idx[1]),
    .ioctl_wr(wr[1]), .ioctl_dout(dout[1]), .ioctl_wait(wt[1]), .mem_addr(ma[1]),
    .mem_data(md[1]), .mem_wr(mw[1]), .mem_busy(busy[1]), .loader_en(en[1]),
    .loader_reset(lr[1]), .done(dn[1]), .overflow(ov[1]));

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // completed writes are popped from the scoreboard in order
  always @(negedge clk_sys) begin
    for (int s = 0; s < 2; s++) begin
      if (!reset && mw[s] && !busy[s]) begin
        nw[s]++;
        if (q.size() == 0) chk("unexpected_write", {7'd0, 1'(s), ma[s], md[s]}, 32'hFFFFFFFF);
        else chk("write", {7'd0, 1'(s), ma[s], md[s]}, {7'd0, q.pop_front()});
      end
    end
  end

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic expect_wr(int s, logic [15:0] a, logic [7:0] d);
    q.push_back({1'(s), a, d});
  endtask

  task automatic send(int s, logic [7:0] b);
    int n = 0;
    while (wt[s] && n < 200) begin tick; n++; end
    chk("send_wait", {31'd0, wt[s]}, 0);
    wr[s] = 1'b1;
    dout[s] = b;
    tick;
    wr[s] = 1'b0;
  endtask

  task automatic drain(int s);
    int n = 0;
    while ((wt[s] || q.size() > 0) && n < 200) begin tick; n++; end
    chk("drain_wait", {31'd0, wt[s]}, 0);
    chk("drain_queue", q.size(), 0);
  endtask

  task automatic start(int s);
    int n = 0;
    dl[s] = 1'b0;
    tick;
    tick;
    idx[s] = 8'd1;
    dl[s] = 1'b1;
    tick;
    chk("loader_reset_pulse", {31'd0, lr[s]}, 1);
    chk("start_flags", {28'd0, en[s], dn[s], ov[s], ma[s] == 16'h2000}, 32'b1001);
    while (wt[s] && n < 100) begin n++; tick; end
    chk("hold_len", n, 4);
    chk("loader_reset_done", {31'd0, lr[s]}, 0);
  endtask

  initial begin
    idx[0] = 8'd0; idx[1] = 8'd0; dout[0] = 8'd0; dout[1] = 8'd0;
    nw[0] = 0; nw[1] = 0;
    tick;
    tick;
    reset = 1'b0;
    tick;
    chk("reset_outputs", {26'd0, wt[0], mw[0], en[0], lr[0], dn[0], ov[0]}, 0);
    chk("reset_addr", ma[0], 32'h2000);
    wr[0] = 1'b1; dout[0] = 8'h42;
    tick;
    wr[0] = 1'b0;
    tick;
    chk("idle_byte_ignored", {31'd0, mw[0]}, 0);
    // literals
    start(0);
    expect_wr(0, 16'h2000, 8'h11); send(0, 8'h11);
    expect_wr(0, 16'h2001, 8'h22); send(0, 8'h22);
    expect_wr(0, 16'h2002, 8'h33); send(0, 8'h33);
    drain(0);
    chk("lit_addr", ma[0], 32'h2003);
    // run of 5 at full rate
    start(0);
    send(0, 8'hED);
    send(0, 8'h05);
    for (int i = 0; i < 5; i++) expect_wr(0, 16'h2000 + 16'(i), 8'hAA);
    wr[0] = 1'b1; dout[0] = 8'hAA;
    tick;
    wr[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("run_wr_wait", {30'd0, mw[0], wt[0]}, 32'b11);
      tick;
    end
    chk("run_end", {30'd0, mw[0], wt[0]}, 0);
    chk("run_queue", q.size(), 0);
    // end marker
    start(0);
    send(0, 8'hED);
    send(0, 8'h00);
    chk("done_set", {31'd0, dn[0]}, 1);
    send(0, 8'h77);
    for (int i = 0; i < 4; i++) begin
      chk("after_end_no_wr", {31'd0, mw[0]}, 0);
      tick;
    end
    // back-pressure
    start(0);
    send(0, 8'hED);
    send(0, 8'h03);
    for (int i = 0; i < 3; i++) expect_wr(0, 16'h2000 + 16'(i), 8'h55);
    nw[0] = 0;
    busy[0] = 1'b1; wr[0] = 1'b1; dout[0] = 8'h55;
    tick;
    wr[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("busy_stable", {7'd0, mw[0], ma[0], md[0]}, {7'd0, 1'b1, 16'h2000, 8'h55});
      tick;
    end
    busy[0] = 1'b0;
    drain(0);
    chk("busy_write_count", nw[0], 3);
    chk("busy_final_addr", ma[0], 32'h2003);
    // overflow on the small instance
    start(1);
    send(1, 8'hED);
    send(1, 8'h04);
    expect_wr(1, 16'h2000, 8'h99);
    expect_wr(1, 16'h2001, 8'h99);
    nw[1] = 0;
    send(1, 8'h99);
    drain(1);
    chk("ovf_flag", {31'd0, ov[1]}, 1);
    chk("ovf_count", nw[1], 2);
    chk("ovf_addr", ma[1], 32'h2002);
    // reset in the middle of a run
    start(1);
    send(1, 8'hED);
    send(1, 8'h10);
    busy[1] = 1'b1; wr[1] = 1'b1; dout[1] = 8'h99;
    tick;
    wr[1] = 1'b0;
    chk("fill_active", {31'd0, mw[1]}, 1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    busy[1] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("post_reset_quiet", {26'd0, wt[1], mw[1], en[1], lr[1], dn[1], ov[1]}, 0);
      tick;
    end
    chk("post_reset_addr", ma[1], 32'h2000);
    chk("final_queue", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
